// File: rtl/eth_10g_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | eth_10g_pkg : shared types and constants for the 10G TX path          |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package eth_10g_pkg;

  localparam int AV_DATA_W  = 64;
  localparam int AV_EMPTY_W = 3;
  localparam int STALL_W    = 16;

  localparam logic [15:0] MAC_TYPE_IPV4 = 16'h0800;
  localparam logic [15:0] MAC_TYPE_ARP  = 16'h0806;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_XFER  = 2'd1,
    ST_ABORT = 2'd2,
    ST_GAP   = 2'd3
  } tx_state_e;

endpackage
`default_nettype wire

// File: rtl/eth_10g_rr_arb.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | eth_10g_rr_arb : combinational round-robin / fixed-priority picker    |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module eth_10g_rr_arb #(
  parameter int NUM_CH = 4,
  parameter int PTR_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [PTR_W-1:0]  ptr,
  input  logic              mode,
  output logic [NUM_CH-1:0] grant
);

  logic             found;
  logic [PTR_W:0]   sum;
  logic [PTR_W-1:0] idx;

  // mode=1 scans from ch0; mode=0 scans from ptr and wraps past NUM_CH-1
  always_comb begin
    grant = '0;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      sum = mode ? (PTR_W+1)'(i) : ({1'b0, ptr} + (PTR_W+1)'(i));
      if (sum >= (PTR_W+1)'(NUM_CH)) sum = sum - (PTR_W+1)'(NUM_CH);
      idx = sum[PTR_W-1:0];
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/eth_10g_tx_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | eth_10g_tx_arbiter : packet-level arbiter of NUM_CH sources onto MAC  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module eth_10g_tx_arbiter
  import eth_10g_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int ARB_MODE = 0,
  parameter int TIMEOUT  = 1024
) (
  input  logic                       clk_156_25,
  input  logic                       rst_n,
  input  logic [NUM_CH-1:0]          ch_req,
  output logic [NUM_CH-1:0]          ch_grant,
  input  logic [NUM_CH-1:0]          ch_sop,
  input  logic [NUM_CH-1:0]          ch_valid,
  input  logic [NUM_CH-1:0]          ch_eop,
  input  logic [NUM_CH-1:0]          ch_error,
  input  logic [AV_EMPTY_W*NUM_CH-1:0] ch_empty,
  input  logic [AV_DATA_W*NUM_CH-1:0]  ch_data,
  output logic [NUM_CH-1:0]          ch_ready,
  output logic                       avalon_st_tx_startofpacket,
  output logic                       avalon_st_tx_valid,
  output logic                       avalon_st_tx_endofpacket,
  output logic                       avalon_st_tx_error,
  output logic [AV_EMPTY_W-1:0]      avalon_st_tx_empty,
  output logic [AV_DATA_W-1:0]       avalon_st_tx_data,
  output logic [1:0]                 avalon_st_pause_data,
  input  logic                       avalon_st_tx_ready,
  output logic                       tx_idle,
  output logic                       timeout_err
);

  localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  tx_state_e            state_q, state_d;
  logic [NUM_CH-1:0]    ch_grant_q, ch_grant_d;
  logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [STALL_W-1:0]   stall_q, stall_d;
  logic                 timeout_err_q, timeout_err_d;

  logic [NUM_CH-1:0]    win;
  logic [PTR_W-1:0]     g_idx;
  logic [PTR_W-1:0]     rr_next;
  logic                 accept;

  eth_10g_rr_arb #(
    .NUM_CH (NUM_CH),
    .PTR_W  (PTR_W)
  ) u_arb (
    .req   (ch_req),
    .ptr   (rr_ptr_q),
    .mode  (ARB_MODE == 1),
    .grant (win)
  );

  always_comb begin
    g_idx = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_grant_q[i]) g_idx = PTR_W'(i);
    end
  end

  always_comb begin
    rr_next = rr_ptr_q;
    if (ARB_MODE == 0) rr_next = (g_idx == PTR_W'(NUM_CH-1)) ? '0 : g_idx + 1'b1;
  end

  assign accept = ch_valid[g_idx] & avalon_st_tx_ready;

  always_comb begin
    state_d       = state_q;
    ch_grant_d    = ch_grant_q;
    rr_ptr_d      = rr_ptr_q;
    stall_d       = stall_q;
    timeout_err_d = 1'b0;
    ch_ready                   = '0;
    avalon_st_tx_startofpacket = 1'b0;
    avalon_st_tx_valid         = 1'b0;
    avalon_st_tx_endofpacket   = 1'b0;
    avalon_st_tx_error         = 1'b0;
    avalon_st_tx_empty         = '0;
    avalon_st_tx_data          = '0;

    case (state_q)
      ST_IDLE: begin
        stall_d = '0;
        if (|ch_req) begin
          ch_grant_d = win;
          state_d    = ST_XFER;
        end
      end
      ST_XFER: begin
        avalon_st_tx_startofpacket = ch_sop[g_idx];
        avalon_st_tx_valid         = ch_valid[g_idx];
        avalon_st_tx_endofpacket   = ch_eop[g_idx];
        avalon_st_tx_error         = ch_error[g_idx];
        avalon_st_tx_empty         = ch_empty[AV_EMPTY_W*g_idx +: AV_EMPTY_W];
        avalon_st_tx_data          = ch_data[AV_DATA_W*g_idx +: AV_DATA_W];
        ch_ready                   = avalon_st_tx_ready ? ch_grant_q : '0;
        if (accept) begin
          stall_d = '0;
          if (ch_eop[g_idx]) begin
            state_d    = ST_GAP;
            ch_grant_d = '0;
            rr_ptr_d   = rr_next;
          end
        end else if (stall_q >= STALL_W'(TIMEOUT-1)) begin
          state_d       = ST_ABORT;
          timeout_err_d = 1'b1;
        end else if (stall_q != '1) begin
          stall_d = stall_q + 1'b1;
        end
      end
      ST_ABORT: begin
        // synthetic terminating beat closes the truncated packet at the MAC
        avalon_st_tx_valid       = 1'b1;
        avalon_st_tx_endofpacket = 1'b1;
        avalon_st_tx_error       = 1'b1;
        if (avalon_st_tx_ready) begin
          state_d    = ST_GAP;
          ch_grant_d = '0;
          rr_ptr_d   = rr_next;
          stall_d    = '0;
        end
      end
      ST_GAP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_156_25 or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      ch_grant_q    <= '0;
      rr_ptr_q      <= '0;
      stall_q       <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ch_grant_q    <= ch_grant_d;
      rr_ptr_q      <= rr_ptr_d;
      stall_q       <= stall_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign ch_grant             = ch_grant_q;
  assign timeout_err          = timeout_err_q;
  assign tx_idle              = (state_q == ST_IDLE) & avalon_st_tx_ready;
  assign avalon_st_pause_data = 2'b00;

endmodule
`default_nettype wire

// File: tb/tb_eth_10g_tx_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_eth_10g_tx_arbiter : directed bench, RR instance and FP instance   |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_eth_10g_tx_arbiter;

  localparam int NCH = 4;

  logic             clk_156_25 = 1'b0;
  logic             rst_n      = 1'b0;
  logic [NCH-1:0]   ch_req   = '0;
  logic [NCH-1:0]   ch_sop   = '0;
  logic [NCH-1:0]   ch_valid = '0;
  logic [NCH-1:0]   ch_eop   = '0;
  logic [NCH-1:0]   ch_error = '0;
  logic [3*NCH-1:0] ch_empty = '0;
  logic [64*NCH-1:0] ch_data = '0;
  logic             mac_ready = 1'b1;
  logic             sel = 1'b0;

  logic [NCH-1:0] grant0, ready0, grant1, ready1;
  logic           sop0, val0, eop0, err0, idle0, terr0;
  logic           sop1, val1, eop1, err1, idle1, terr1;
  logic [2:0]     emp0, emp1;
  logic [63:0]    dat0, dat1;
  logic [1:0]     pause0, pause1;

  logic [NCH-1:0] w_grant, w_ready;
  logic           w_sop, w_valid, w_eop, w_err, w_idle, w_terr;
  logic [2:0]     w_empty;
  logic [63:0]    w_data;

  assign w_grant = sel ? grant1 : grant0;
  assign w_ready = sel ? ready1 : ready0;
  assign w_sop   = sel ? sop1   : sop0;
  assign w_valid = sel ? val1   : val0;
  assign w_eop   = sel ? eop1   : eop0;
  assign w_err   = sel ? err1   : err0;
  assign w_idle  = sel ? idle1  : idle0;
  assign w_terr  = sel ? terr1  : terr0;
  assign w_empty = sel ? emp1   : emp0;
  assign w_data  = sel ? dat1   : dat0;

  always #5 clk_156_25 = ~clk_156_25;

  eth_10g_tx_arbiter #(.NUM_CH(NCH), .ARB_MODE(0), .TIMEOUT(16)) dut0 (
    .clk_156_25(clk_156_25), .rst_n(rst_n), .ch_req(ch_req), .ch_grant(grant0),
    .ch_sop(ch_sop), .ch_valid(ch_valid), .ch_eop(ch_eop), .ch_error(ch_error),
    .ch_empty(ch_empty), .ch_data(ch_data), .ch_ready(ready0),
    .avalon_st_tx_startofpacket(sop0), .avalon_st_tx_valid(val0),
    .avalon_st_tx_endofpacket(eop0), .avalon_st_tx_error(err0),
    .avalon_st_tx_empty(emp0), .avalon_st_tx_data(dat0),
    .avalon_st_pause_data(pause0), .avalon_st_tx_ready(mac_ready),
    .tx_idle(idle0), .timeout_err(terr0)
  );

  eth_10g_tx_arbiter #(.NUM_CH(NCH), .ARB_MODE(1), .TIMEOUT(1024)) dut1 (
    .clk_156_25(clk_156_25), .rst_n(rst_n), .ch_req(ch_req), .ch_grant(grant1),
    .ch_sop(ch_sop), .ch_valid(ch_valid), .ch_eop(ch_eop), .ch_error(ch_error),
    .ch_empty(ch_empty), .ch_data(ch_data), .ch_ready(ready1),
    .avalon_st_tx_startofpacket(sop1), .avalon_st_tx_valid(val1),
    .avalon_st_tx_endofpacket(eop1), .avalon_st_tx_error(err1),
    .avalon_st_tx_empty(emp1), .avalon_st_tx_data(dat1),
    .avalon_st_pause_data(pause1), .avalon_st_tx_ready(mac_ready),
    .tx_idle(idle1), .timeout_err(terr1)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] pat(input int ch, input int b);
    return {16'hC0DE, 8'(ch), 8'h00, 32'(b)};
  endfunction

  task automatic step();
    @(posedge clk_156_25);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    ch_req    = '0;
    ch_sop    = '0;
    ch_valid  = '0;
    ch_eop    = '0;
    ch_error  = '0;
    mac_ready = 1'b1;
    for (int c = 0; c < NCH; c++) ch_data[64*c +: 64] = {16'hBAD0, 48'(c)};
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic wait_grant(input logic [NCH-1:0] exp, input string tag);
    int cyc;
    cyc = 0;
    #1;
    while (w_grant == '0 && cyc < 10) begin
      step();
      #1;
      cyc++;
    end
    check(tag, w_grant, exp);
  endtask

  // channel model: holds each beat until ch_ready, MAC side checked on every MAC accept
  task automatic run_pkt(input int ch, input int n, input bit toggle, input bit with_eop,
                         output int mac_beats);
    int b;
    int cyc;
    b = 0;
    cyc = 0;
    mac_beats = 0;
    while (b < n && cyc < 100) begin
      if (toggle) mac_ready = cyc[0];
      ch_valid = '0; ch_valid[ch] = 1'b1;
      ch_sop   = '0; ch_sop[ch]   = (b == 0);
      ch_eop   = '0; ch_eop[ch]   = with_eop && (b == n-1);
      ch_data[64*ch +: 64] = pat(ch, b);
      #1;
      check("xfer_grant", w_grant, 64'(1) << ch);
      check("ch_ready", w_ready, mac_ready ? (64'(1) << ch) : 64'd0);
      if (w_valid && mac_ready) begin
        mac_beats++;
        check("mac_data", w_data, pat(ch, b));
        check("mac_sop", w_sop, b == 0);
        check("mac_eop", w_eop, with_eop && (b == n-1));
        check("mac_err", w_err, 0);
      end
      if (w_ready[ch]) b++;
      cyc++;
      step();
    end
    if (b < n) check("pkt_budget", b, n);
    ch_valid  = '0;
    ch_sop    = '0;
    ch_eop    = '0;
    mac_ready = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int beats;
    int n_to, n_beat, quiet;
    logic [8:0] flags;

    // reset state and single request
    sel = 1'b0;
    do_reset();
    check("rst_grant", w_grant, 0);
    check("rst_valid", w_valid, 0);
    check("rst_ready", w_ready, 0);
    check("rst_terr", w_terr, 0);
    ch_req = 4'b0010;
    #1;
    check("grant_before", w_grant, 0);
    check("idle_before", w_idle, 1);
    check("pause", pause0, 0);
    step();
    ch_req = '0;
    #1;
    check("grant_lat1", w_grant, 4'b0010);
    run_pkt(1, 3, 1'b0, 1'b1, beats);
    check("single_beats", beats, 3);
    #1;
    check("gap_idle", w_idle, 0);
    check("gap_valid", w_valid, 0);
    check("gap_grant", w_grant, 0);
    step();
    #1;
    check("idle_return", w_idle, 1);

    // round-robin fairness
    do_reset();
    ch_req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_grant(4'(1 << (k % 4)), "rr_order");
      run_pkt(k % 4, 1, 1'b0, 1'b1, beats);
    end
    ch_req = '0;

    // fixed priority instance
    sel = 1'b1;
    do_reset();
    ch_req = 4'b1100;
    wait_grant(4'b0100, "fp_first");
    ch_req = 4'b1001;
    run_pkt(2, 3, 1'b0, 1'b1, beats);
    wait_grant(4'b0001, "fp_ch0_next");
    ch_req = 4'b1000;
    run_pkt(0, 1, 1'b0, 1'b1, beats);
    wait_grant(4'b1000, "fp_ch3_last");
    ch_req = '0;
    run_pkt(3, 1, 1'b0, 1'b1, beats);
    sel = 1'b0;

    // backpressure
    do_reset();
    ch_req = 4'b1000;
    wait_grant(4'b1000, "bp_grant");
    ch_req = '0;
    run_pkt(3, 8, 1'b1, 1'b1, beats);
    check("bp_beats", beats, 8);

    // timeout abort on ch0
    do_reset();
    ch_req = 4'b0001;
    wait_grant(4'b0001, "to_grant");
    ch_req = '0;
    run_pkt(0, 2, 1'b0, 1'b0, beats);
    n_to = 0; n_beat = 0; quiet = 0; flags = '0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (w_terr) n_to++;
      if (w_valid && mac_ready) begin
        n_beat++;
        flags = {w_sop, w_eop, w_err, w_empty, (w_data == 64'd0), (w_ready == '0), w_terr};
      end else if (n_beat == 0) begin
        quiet++;
      end
      step();
    end
    check("to_beats", n_beat, 1);
    check("to_pulses", n_to, 1);
    check("to_flags", flags, 9'b0_1_1_000_1_1_1);
    check("to_stall_len", quiet, 16);
    check("to_rr_ptr", dut0.rr_ptr_q, 1);
    ch_req = 4'b0011;
    wait_grant(4'b0010, "to_rr_next");
    ch_req = '0;
    run_pkt(1, 1, 1'b0, 1'b1, beats);

    // reset during beat 2
    ch_req = 4'b0001;
    wait_grant(4'b0001, "mid_grant");
    ch_req = '0;
    run_pkt(0, 1, 1'b0, 1'b0, beats);
    ch_valid = 4'b0001;
    ch_data[63:0] = pat(0, 1);
    #1;
    check("mid_beat2", w_valid, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_data", w_data, 0);
    check("mid_rst_ctrl", {w_sop, w_valid, w_eop, w_err, w_empty, w_ready, w_grant, w_terr}, 0);
    step();
    step();
    ch_valid = '0;
    rst_n = 1'b1;
    #1;
    check("mid_rr_ptr", dut0.rr_ptr_q, 0);
    check("mid_no_abort", w_valid, 0);
    ch_req = 4'b0100;
    wait_grant(4'b0100, "mid_regrant");
    ch_req = '0;
    run_pkt(2, 1, 1'b0, 1'b1, beats);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
